// File: rtl/sd_resp_pkg.sv
// Shared state encoding and sector geometry for the SD sector responder.
package sd_resp_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int SECTOR_SHIFT = 9;
    localparam int BYTE_IDX_W   = 9;

    typedef enum logic [2:0] {
        IDLE,
        RD_MEM,
        RD_PUT,
        WR_ADDR,
        WR_LAT,
        WR_MEM,
        DONE
    } state_t;

endpackage

// File: rtl/sd_sector_responder.sv
// Answers sd_rd/sd_wr with a 512-byte sector streamed to/from byte-wide memory; >=2 cycles/byte, stalls on mem_ready.
// Optional SD_SECTOR_RESPONDER_WPROTECT_EN adds write_protect/wp_hit (protected writes handshake but never touch memory).
module sd_sector_responder
    import sd_resp_pkg::*;
#(
    parameter int                ADDR_W   = 24,
    parameter logic [ADDR_W-1:0] IMG_BASE = '0,
    parameter int                MAX_LBA  = 454
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              img_mounted,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    input  logic [7:0]        sd_buff_din,
    output logic              sd_buff_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
`ifdef SD_SECTOR_RESPONDER_WPROTECT_EN
    input  logic              write_protect,
    output logic              wp_hit,
`endif
    output logic              err
);

    state_t                  state_q, state_d;
    logic [BYTE_IDX_W-1:0]   idx_q, idx_d;
    logic                    bad_q, bad_d;
    logic                    wp_q, wp_d;
    logic                    sd_ack_q, sd_ack_d;
    logic [8:0]              sd_buff_addr_q, sd_buff_addr_d;
    logic [7:0]              sd_buff_dout_q, sd_buff_dout_d;
    logic                    sd_buff_wr_q, sd_buff_wr_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [7:0]              mem_wdata_q, mem_wdata_d;
    logic                    err_q, err_d;

    logic last_byte;
    assign last_byte = (idx_q == BYTE_IDX_W'(SECTOR_BYTES - 1));

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        bad_d          = bad_q;
        wp_d           = wp_q;
        sd_ack_d       = sd_ack_q;
        sd_buff_addr_d = sd_buff_addr_q;
        sd_buff_dout_d = sd_buff_dout_q;
        sd_buff_wr_d   = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        err_d          = err_q;

        case (state_q)
            IDLE: begin
                if (sd_rd || sd_wr) begin
                    bad_d          = !img_mounted || (sd_lba > 32'(MAX_LBA));
                    err_d          = err_q | bad_d;
                    sd_ack_d       = 1'b1;
                    idx_d          = '0;
                    sd_buff_addr_d = '0;
                    mem_addr_d     = IMG_BASE + (ADDR_W'(sd_lba) << SECTOR_SHIFT);
`ifdef SD_SECTOR_RESPONDER_WPROTECT_EN
                    wp_d           = !sd_rd && write_protect;
`else
                    wp_d           = 1'b0;
`endif
                    // Read has priority when both request levels are high.
                    state_d        = sd_rd ? RD_MEM : WR_ADDR;
                end
            end
            RD_MEM: begin
                if (bad_q || mem_ready) begin
                    sd_buff_dout_d = bad_q ? 8'h00 : mem_rdata;
                    sd_buff_addr_d = idx_q;
                    sd_buff_wr_d   = 1'b1;
                    state_d        = RD_PUT;
                end
            end
            RD_PUT: begin
                if (last_byte) begin
                    state_d = DONE;
                end else begin
                    idx_d      = idx_q + 1'b1;
                    mem_addr_d = mem_addr_q + 1'b1;
                    state_d    = RD_MEM;
                end
            end
            WR_ADDR: state_d = WR_LAT;
            WR_LAT: begin
                // Client data is registered one edge after it sees the address.
                mem_wdata_d = sd_buff_din;
                state_d     = WR_MEM;
            end
            WR_MEM: begin
                if (bad_q || wp_q || mem_ready) begin
                    if (last_byte) begin
                        state_d = DONE;
                    end else begin
                        idx_d          = idx_q + 1'b1;
                        sd_buff_addr_d = idx_q + 1'b1;
                        mem_addr_d     = mem_addr_q + 1'b1;
                        state_d        = WR_ADDR;
                    end
                end
            end
            DONE: begin
                sd_ack_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            bad_q          <= 1'b0;
            wp_q           <= 1'b0;
            sd_ack_q       <= 1'b0;
            sd_buff_addr_q <= '0;
            sd_buff_dout_q <= '0;
            sd_buff_wr_q   <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            bad_q          <= bad_d;
            wp_q           <= wp_d;
            sd_ack_q       <= sd_ack_d;
            sd_buff_addr_q <= sd_buff_addr_d;
            sd_buff_dout_q <= sd_buff_dout_d;
            sd_buff_wr_q   <= sd_buff_wr_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            err_q          <= err_d;
        end
    end

    assign sd_ack       = sd_ack_q;
    assign sd_buff_addr = sd_buff_addr_q;
    assign sd_buff_dout = sd_buff_dout_q;
    assign sd_buff_wr   = sd_buff_wr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign err          = err_q;
    assign mem_rd       = (state_q == RD_MEM) && !bad_q;
    assign mem_wr       = (state_q == WR_MEM) && !bad_q && !wp_q;
`ifdef SD_SECTOR_RESPONDER_WPROTECT_EN
    assign wp_hit       = (state_q == DONE) && wp_q;
`endif

endmodule

// File: tb/tb_sd_sector_responder.sv
// Scoreboard bench for sd_sector_responder: sector reads/writes, range errors, back-to-back and reset.
module tb_sd_sector_responder;

    logic        clk = 1'b0;
    logic        reset, img_mounted, sd_rd, sd_wr, mem_ready;
    logic [31:0] sd_lba;
    logic [7:0]  sd_buff_din, mem_rdata, sd_buff_dout, mem_wdata;
    logic        sd_ack, sd_buff_wr, mem_rd, mem_wr, err;
    logic [8:0]  sd_buff_addr;
    logic [23:0] mem_addr;
`ifdef SD_SECTOR_RESPONDER_WPROTECT_EN
    logic        write_protect, wp_hit;
`endif

    always #5 clk = ~clk;

    sd_sector_responder dut (
        .clk(clk), .reset(reset), .img_mounted(img_mounted), .sd_lba(sd_lba),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
        .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
`ifdef SD_SECTOR_RESPONDER_WPROTECT_EN
        .write_protect(write_protect), .wp_hit(wp_hit),
`endif
        .err(err)
    );

    logic [7:0] mem [0:16383];
    assign mem_rdata = mem[mem_addr[13:0]];

    // Client buffer: byte i holds i^0x5A, registered one edge after the address.
    always @(posedge clk) sd_buff_din <= sd_buff_addr[7:0] ^ 8'h5A;

    int assertions = 0;
    int failures   = 0;
    int strobes, rd_cyc, wr_hs, wp_pulses, lows, wait_cnt;
    bit done_ok, stall_en;
    logic [16:0] rexp_q[$];
    logic [31:0] wexp_q[$];

    function automatic logic [7:0] img2(int k);
        return 8'(k + 37 * (k >> 9));
    endfunction

    task automatic fill_img2();
        for (int k = 0; k < 16384; k++) mem[k] = img2(k);
    endtask

    task automatic push_read(int lba);
        for (int i = 0; i < 512; i++) rexp_q.push_back({9'(i), img2(lba * 512 + i)});
    endtask

    task automatic run_sector(input bit rd, input bit wr, input logic [31:0] lba,
                              input int reset_at, input int budget);
        bit acked = 1'b0;
        bit pend  = 1'b0;
        logic [23:0] paddr;
        logic [7:0]  pdata;
        logic [16:0] e17;
        logic [31:0] e32;
        strobes = 0; rd_cyc = 0; wr_hs = 0; wp_pulses = 0; lows = 0; done_ok = 1'b0;
        sd_lba = lba; sd_rd = rd; sd_wr = wr;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (sd_buff_wr) begin
                strobes++;
                assertions++;
                if (rexp_q.size() == 0) begin
                    failures++;
                    $display("FAIL strobe_extra: addr=%0d data=%02h, required no strobe", sd_buff_addr, sd_buff_dout);
                end else begin
                    e17 = rexp_q.pop_front();
                    if ({sd_buff_addr, sd_buff_dout} !== e17) begin
                        failures++;
                        $display("FAIL strobe_data: addr=%0d data=%02h, required addr=%0d data=%02h",
                                 sd_buff_addr, sd_buff_dout, e17[16:8], e17[7:0]);
                    end
                end
            end
            if (mem_rd) rd_cyc++;
`ifdef SD_SECTOR_RESPONDER_WPROTECT_EN
            if (wp_hit) wp_pulses++;
`endif
            if (pend) begin
                assertions++;
                if (!mem_wr || mem_addr !== paddr || mem_wdata !== pdata) begin
                    failures++;
                    $display("FAIL mem_wr_hold: wr=%0b addr=%06h data=%02h, required wr=1 addr=%06h data=%02h",
                             mem_wr, mem_addr, mem_wdata, paddr, pdata);
                end
            end
            if (reset_at >= 0 && mem_wr && sd_buff_addr == 9'(reset_at)) begin
                reset = 1'b1;
                @(negedge clk);
                assertions++;
                if ({sd_ack, mem_wr, mem_rd, sd_buff_wr, err} !== 5'b0) begin
                    failures++;
                    $display("FAIL reset_mid_write: ack/wr/rd/strobe/err=%05b, required 00000",
                             {sd_ack, mem_wr, mem_rd, sd_buff_wr, err});
                end
                assertions++;
                if (sd_buff_addr !== 9'd0 || mem_addr !== 24'd0) begin
                    failures++;
                    $display("FAIL reset_mid_addr: buff_addr=%0d mem_addr=%06h, required 0 0", sd_buff_addr, mem_addr);
                end
                reset = 1'b0; sd_rd = 1'b0; sd_wr = 1'b0; mem_ready = !stall_en;
                done_ok = 1'b1;
                return;
            end
            if (mem_rd || mem_wr) begin
                if (stall_en && wait_cnt > 0) begin
                    mem_ready = 1'b0;
                    wait_cnt--;
                end else begin
                    mem_ready = 1'b1;
                    wait_cnt  = stall_en ? int'($urandom_range(0, 3)) : 0;
                    if (mem_wr) begin
                        wr_hs++;
                        assertions++;
                        if (wexp_q.size() == 0) begin
                            failures++;
                            $display("FAIL mem_write_extra: addr=%06h data=%02h, required no write", mem_addr, mem_wdata);
                        end else begin
                            e32 = wexp_q.pop_front();
                            if ({mem_addr, mem_wdata} !== e32) begin
                                failures++;
                                $display("FAIL mem_write: addr=%06h data=%02h, required addr=%06h data=%02h",
                                         mem_addr, mem_wdata, e32[31:8], e32[7:0]);
                            end
                        end
                        mem[mem_addr[13:0]] = mem_wdata;
                    end
                end
            end else begin
                mem_ready = !stall_en;
            end
            pend  = mem_wr && !mem_ready;
            paddr = mem_addr;
            pdata = mem_wdata;
            if (!acked) begin
                if (sd_ack) begin
                    acked = 1'b1; sd_rd = 1'b0; sd_wr = 1'b0;
                end else begin
                    lows++;
                end
            end else if (!sd_ack) begin
                done_ok = 1'b1;
                break;
            end
        end
        sd_rd = 1'b0; sd_wr = 1'b0; mem_ready = !stall_en;
        assertions++;
        if (!done_ok) begin
            failures++;
            $display("FAIL sector_timeout: lba=%0d ack=%0b acked=%0b, required ack fall within %0d cycles",
                     lba, sd_ack, acked, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        assertions++;
        if ({sd_ack, sd_buff_wr, mem_rd, mem_wr, err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: ack/strobe/rd/wr/err=%05b, required 00000", {sd_ack, sd_buff_wr, mem_rd, mem_wr, err});
        end
        assertions++;
        if ({sd_buff_addr, sd_buff_dout, mem_wdata} !== 25'd0 || mem_addr !== 24'd0) begin
            failures++;
            $display("FAIL reset_data: buff_addr=%0d dout=%02h wdata=%02h mem_addr=%06h, required all 0",
                     sd_buff_addr, sd_buff_dout, mem_wdata, mem_addr);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        assertions++;
        if (sd_ack !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_ack: sd_ack=%0b, required 0", sd_ack);
        end
    endtask

    task automatic test_read();
        for (int k = 0; k < 16384; k++) mem[k] = 8'(k);
        stall_en = 1'b0;
        for (int i = 0; i < 512; i++) rexp_q.push_back({9'(i), 8'(1024 + i)});
        run_sector(1'b1, 1'b0, 2, -1, 4000);
        assertions++;
        if (strobes != 512 || rexp_q.size() != 0) begin
            failures++;
            $display("FAIL read_count: strobes=%0d left=%0d, required 512 0", strobes, rexp_q.size());
        end
        assertions++;
        if (rd_cyc != 512 || err !== 1'b0) begin
            failures++;
            $display("FAIL read_mem: rd_cycles=%0d err=%0b, required 512 0", rd_cyc, err);
        end
    endtask

    task automatic test_write();
        int bad = 0;
        stall_en = 1'b1;
        wait_cnt = 0;
        for (int i = 0; i < 512; i++) wexp_q.push_back({24'(i), 8'(i) ^ 8'h5A});
        run_sector(1'b0, 1'b1, 0, -1, 8000);
        assertions++;
        if (wr_hs != 512 || wexp_q.size() != 0 || strobes != 0 || rd_cyc != 0) begin
            failures++;
            $display("FAIL write_count: writes=%0d left=%0d strobes=%0d rd=%0d, required 512 0 0 0",
                     wr_hs, wexp_q.size(), strobes, rd_cyc);
        end
        for (int i = 0; i < 512; i++) if (mem[i] !== (8'(i) ^ 8'h5A)) bad++;
        assertions++;
        if (bad != 0 || err !== 1'b0) begin
            failures++;
            $display("FAIL write_image: wrong_bytes=%0d err=%0b, required 0 0", bad, err);
        end
    endtask

    task automatic test_range();
        fill_img2();
        stall_en = 1'b0;
        for (int i = 0; i < 512; i++) rexp_q.push_back({9'(i), 8'h00});
        run_sector(1'b1, 1'b0, 455, -1, 4000);
        assertions++;
        if (strobes != 512 || rd_cyc != 0 || err !== 1'b1 || rexp_q.size() != 0) begin
            failures++;
            $display("FAIL range_read: strobes=%0d rd=%0d err=%0b left=%0d, required 512 0 1 0",
                     strobes, rd_cyc, err, rexp_q.size());
        end
        // Both request levels high: read must win.
        push_read(7);
        run_sector(1'b1, 1'b1, 7, -1, 4000);
        assertions++;
        if (strobes != 512 || rd_cyc != 512 || wr_hs != 0 || err !== 1'b1) begin
            failures++;
            $display("FAIL range_sticky: strobes=%0d rd=%0d wr=%0d err=%0b, required 512 512 0 1",
                     strobes, rd_cyc, wr_hs, err);
        end
        img_mounted = 1'b0;
        run_sector(1'b0, 1'b1, 3, -1, 4000);
        img_mounted = 1'b1;
        assertions++;
        if (wr_hs != 0 || mem[3 * 512 + 10] !== img2(3 * 512 + 10)) begin
            failures++;
            $display("FAIL unmounted_write: writes=%0d byte=%02h, required 0 %02h",
                     wr_hs, mem[3 * 512 + 10], img2(3 * 512 + 10));
        end
    endtask

    task automatic test_back_to_back();
        int total = 0;
        stall_en = 1'b1;
        wait_cnt = 0;
        for (int n = 0; n < 13; n++) begin
            push_read(13 + n);
            run_sector(1'b1, 1'b0, 13 + n, -1, 6000);
            total += strobes;
            if (n > 0) begin
                assertions++;
                if (lows != 0) begin
                    failures++;
                    $display("FAIL b2b_gap: extra_low_cycles=%0d at lba=%0d, required 0", lows, 13 + n);
                end
            end
        end
        assertions++;
        if (total != 6656 || rexp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_total: strobes=%0d left=%0d, required 6656 0", total, rexp_q.size());
        end
        stall_en = 1'b0;
        mem_ready = 1'b1;
    endtask

    task automatic test_reset_mid_write();
        stall_en = 1'b0;
        for (int i = 0; i < 512; i++) wexp_q.push_back({24'(i), 8'(i) ^ 8'h5A});
        run_sector(1'b0, 1'b1, 0, 200, 4000);
        wexp_q.delete();
        push_read(4);
        run_sector(1'b1, 1'b0, 4, -1, 4000);
        assertions++;
        if (strobes != 512 || rexp_q.size() != 0 || err !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_read: strobes=%0d left=%0d err=%0b, required 512 0 0",
                     strobes, rexp_q.size(), err);
        end
    endtask

`ifdef SD_SECTOR_RESPONDER_WPROTECT_EN
    task automatic test_wprotect();
        int bad = 0;
        stall_en = 1'b0;
        write_protect = 1'b1;
        run_sector(1'b0, 1'b1, 1, -1, 4000);
        write_protect = 1'b0;
        for (int i = 512; i < 1024; i++) if (mem[i] !== img2(i)) bad++;
        assertions++;
        if (wr_hs != 0 || bad != 0 || wp_pulses != 1) begin
            failures++;
            $display("FAIL wprotect: writes=%0d changed=%0d wp_pulses=%0d, required 0 0 1", wr_hs, bad, wp_pulses);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; img_mounted = 1'b1; sd_rd = 1'b0; sd_wr = 1'b0;
        sd_lba = '0; mem_ready = 1'b1; stall_en = 1'b0; wait_cnt = 0;
`ifdef SD_SECTOR_RESPONDER_WPROTECT_EN
        write_protect = 1'b0;
`endif
        test_reset();
        test_read();
        test_write();
        test_range();
        test_back_to_back();
        test_reset_mid_write();
`ifdef SD_SECTOR_RESPONDER_WPROTECT_EN
        test_wprotect();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
